// File: rtl/cpu_vector_seq_pkg.sv
// Shared types and constants for the vector issue sequencer.
package cpu_vector_pkg;

    localparam int INSTR_W  = 30;
    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_SUM   = 4'b0000,
        OP_SUMFV = 4'b0001,
        OP_SUMI  = 4'b0010,
        OP_MULFV = 4'b0011,
        OP_SUBI  = 4'b0100,
        OP_LDV   = 4'b0101,
        OP_CMPEQ = 4'b0110,
        OP_NOP   = 4'b0111,
        OP_JEQ   = 4'b1000,
        OP_J     = 4'b1001,
        OP_SETI  = 4'b1010,
        OP_SETFV = 4'b1011
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cpu_vector_seq_if.sv
// Fetch/datapath-facing bundle of the issue sequencer.
// master = CPU side (fetch + datapath), slave = sequencer.
interface cpu_vector_seq_if #(
    parameter int LANES   = 4,
    parameter int INSTR_W = cpu_vector_pkg::INSTR_W
);
    localparam int LANE_W = $clog2(LANES);

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               cmp_flag;
    logic               mem_ready;
    logic               stall;
    logic               flush;
    logic               pc_sel;
    logic               lane_en;
    logic [LANE_W-1:0]  lane_idx;
    logic [3:0]         vec_op;
    logic               vec_done;

    modport master (
        output instr, instr_valid, cmp_flag, mem_ready,
        input  stall, flush, pc_sel, lane_en, lane_idx, vec_op, vec_done
    );

    modport slave (
        input  instr, instr_valid, cmp_flag, mem_ready,
        output stall, flush, pc_sel, lane_en, lane_idx, vec_op, vec_done
    );

endinterface

// File: rtl/cpu_vector_seq_op_decode.sv
// Opcode classifier: which ops expand over lanes, touch memory, or branch.
module cpu_vector_op_decode
    import cpu_vector_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                is_vec_o,
    output logic                is_mem_o,
    output logic                is_jump_o,
    output logic                is_cond_o
);

    // Pure lookup; unlisted opcodes fall through as pass-through.
    always_comb begin
        is_vec_o  = 1'b0;
        is_mem_o  = 1'b0;
        is_jump_o = 1'b0;
        is_cond_o = 1'b0;
        case (opcode_i)
            OP_SUMFV, OP_MULFV, OP_SETFV: is_vec_o = 1'b1;
            OP_LDV: begin
                is_vec_o = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_J:   is_jump_o = 1'b1;
            OP_JEQ: begin
                is_jump_o = 1'b1;
                is_cond_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_vector_seq.sv
// Vector issue sequencer between IF and the vector datapath.
// Optional macro CPU_VECTOR_SEQ_PERF_EN adds stall / vector-completion counters.
module cpu_vector_seq
    import cpu_vector_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int INSTR_W = cpu_vector_pkg::INSTR_W
) (
    input  logic             clk,
    input  logic             rst,
    cpu_vector_seq_if.slave  bus
`ifdef CPU_VECTOR_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [15:0]      perf_vec_cnt
`endif
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    seq_state_e        state_q, state_d;
    logic [LANE_W-1:0] lane_idx_q, lane_idx_d;
    logic              lane_en_q, lane_en_d;
    logic [3:0]        vec_op_q, vec_op_d;
    logic              mem_q, mem_d;

    logic              is_vec, is_mem, is_jump, is_cond;
    logic              accept_vec, take_jump, advance, last_lane;
    logic              stall, flush, pc_sel, vec_done;

    cpu_vector_op_decode u_dec (
        .opcode_i  (bus.instr[INSTR_W-1 -: OPCODE_W]),
        .is_vec_o  (is_vec),
        .is_mem_o  (is_mem),
        .is_jump_o (is_jump),
        .is_cond_o (is_cond)
    );

    // New instructions are only looked at in IDLE; RUN/FLUSH ignore instr_valid.
    assign accept_vec = (state_q == IDLE) && bus.instr_valid && is_vec;
    assign take_jump  = (state_q == IDLE) && bus.instr_valid && is_jump
                        && (!is_cond || bus.cmp_flag);
    // LDV lanes wait on memory; other vector ops advance every cycle.
    assign advance    = !mem_q || bus.mem_ready;
    assign last_lane  = (state_q == RUN) && advance && (lane_idx_q == LAST_LANE);

    // State register and lane bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            lane_idx_q <= '0;
            lane_en_q  <= 1'b0;
            vec_op_q   <= '0;
            mem_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            lane_en_q  <= lane_en_d;
            vec_op_q   <= vec_op_d;
            mem_q      <= mem_d;
        end
    end

    // Next-state logic: accept vector op or jump in IDLE, walk lanes in RUN.
    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        lane_en_d  = lane_en_q;
        vec_op_d   = vec_op_q;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (accept_vec) begin
                    state_d    = RUN;
                    lane_idx_d = '0;
                    lane_en_d  = 1'b1;
                    vec_op_d   = bus.instr[INSTR_W-1 -: OPCODE_W];
                    mem_d      = is_mem;
                end else if (take_jump) begin
                    state_d = FLUSH;
                end
            end
            RUN: begin
                if (last_lane) begin
                    state_d    = IDLE;
                    lane_idx_d = '0;
                    lane_en_d  = 1'b0;
                end else if (advance) begin
                    lane_idx_d = lane_idx_q + LANE_W'(1);
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline-control outputs. vec_done is decoded from the registered lane
    // state, qualified by mem_ready so it lines up with the completing lane.
    // All forced low while reset is asserted so an aborted op never completes.
    always_comb begin
        stall    = 1'b0;
        flush    = 1'b0;
        pc_sel   = 1'b0;
        vec_done = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    stall  = accept_vec;
                    flush  = take_jump;
                    pc_sel = take_jump;
                end
                RUN: begin
                    stall    = !last_lane;
                    vec_done = last_lane;
                end
                FLUSH:   flush = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.stall    = stall;
    assign bus.flush    = flush;
    assign bus.pc_sel   = pc_sel;
    assign bus.vec_done = vec_done;
    assign bus.lane_en  = lane_en_q;
    assign bus.lane_idx = lane_idx_q;
    assign bus.vec_op   = vec_op_q;

`ifdef CPU_VECTOR_SEQ_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_vec_q;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_vec_q   <= '0;
        end else begin
            if (stall)    perf_stall_q <= perf_stall_q + 32'd1;
            if (vec_done) perf_vec_q   <= perf_vec_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_vec_cnt   = perf_vec_q;
`endif

endmodule

// File: tb/tb_cpu_vector_seq.sv
// Bench for cpu_vector_seq: directed cases plus random traffic against a
// transaction-level model of the sequencer.
module tb_cpu_vector_seq;

    localparam int LANES = 4;

    localparam logic [29:0] I_SUMI  = 30'b001000100000000000000000001111;
    localparam logic [29:0] I_SUMFV = 30'b000100010010000000000000000000;
    localparam logic [29:0] I_LDV   = 30'b010110111000000000000000000000;
    localparam logic [29:0] I_JEQ   = 30'b100000000000000000000000000011;
    localparam logic [29:0] I_MULFV = 30'b001100000000000000000000000101;
    localparam logic [29:0] I_SETFV = 30'b101100000000000000000000000001;
    localparam logic [29:0] I_J     = 30'b100100000000000000000000010000;
    localparam logic [29:0] I_NOP   = 30'b011100000000000000000000000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cpu_vector_seq_if #(.LANES(LANES)) bus ();

`ifdef CPU_VECTOR_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_vec_cnt;
`endif

    cpu_vector_seq #(.LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CPU_VECTOR_SEQ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_vec_cnt   (perf_vec_cnt)
`endif
    );

    int checks = 0, failures = 0, cyc = 0;

    // Model: either working through a vector op, draining a flush, or idle.
    bit         m_busy = 0, m_flush = 0;
    int         m_lane = 0;
    logic [3:0] m_op   = '0;
    int         exp_pstall = 0, exp_pvec = 0;

    // Event tallies for per-scenario totals.
    int stall_seen, flush_seen, pcsel_seen, done_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_vec_op(input logic [3:0] op);
        return op inside {4'b0001, 4'b0011, 4'b0101, 4'b1011};
    endfunction

    // One clock: drive, check against model, then advance the model.
    task automatic step(input logic r, input logic v, input logic [29:0] ins,
                        input logic cf, input logic mr);
        logic [3:0] op;
        logic e_stall, e_flush, e_pcsel, e_done, adv, last;
        @(negedge clk);
        rst = r; bus.instr = ins; bus.instr_valid = v;
        bus.cmp_flag = cf; bus.mem_ready = mr;
        #1;
        op = ins[29:26];
        e_stall = 0; e_flush = 0; e_pcsel = 0; e_done = 0; adv = 0; last = 0;
        if (m_busy) begin
            adv     = (m_op != 4'b0101) || mr;
            last    = adv && (m_lane == LANES - 1);
            e_done  = last;
            e_stall = !last;
        end else if (m_flush) begin
            e_flush = 1;
        end else if (v && is_vec_op(op)) begin
            e_stall = 1;
        end else if (v && (op == 4'b1001 || (op == 4'b1000 && cf))) begin
            e_pcsel = 1;
            e_flush = 1;
        end
        if (!r) begin
            e_stall = 0; e_flush = 0; e_pcsel = 0; e_done = 0;
        end
        chk("stall",    32'(bus.stall),    32'(e_stall));
        chk("flush",    32'(bus.flush),    32'(e_flush));
        chk("pc_sel",   32'(bus.pc_sel),   32'(e_pcsel));
        chk("vec_done", 32'(bus.vec_done), 32'(e_done));
        chk("lane_en",  32'(bus.lane_en),  32'(m_busy));
        chk("lane_idx", 32'(bus.lane_idx), m_busy ? m_lane : 0);
        if (m_busy) chk("vec_op", 32'(bus.vec_op), 32'(m_op));
`ifdef CPU_VECTOR_SEQ_PERF_EN
        chk("perf_stall", perf_stall_cnt, exp_pstall);
        chk("perf_vec",   32'(perf_vec_cnt), exp_pvec);
`endif
        stall_seen += int'(bus.stall);
        flush_seen += int'(bus.flush);
        pcsel_seen += int'(bus.pc_sel);
        done_seen  += int'(bus.vec_done);
        // Effect of the coming rising edge.
        if (!r) begin
            m_busy = 0; m_flush = 0; m_lane = 0; m_op = '0;
            exp_pstall = 0; exp_pvec = 0;
        end else begin
            exp_pstall += int'(e_stall);
            exp_pvec   += int'(e_done);
            if (m_busy) begin
                if (last) begin
                    m_busy = 0;
                    m_lane = 0;
                end else if (adv) begin
                    m_lane++;
                end
            end else if (m_flush) begin
                m_flush = 0;
            end else if (v && is_vec_op(op)) begin
                m_busy = 1;
                m_lane = 0;
                m_op   = op;
            end else if (e_pcsel) begin
                m_flush = 1;
            end
        end
        cyc++;
    endtask

    task automatic clear_tally();
        stall_seen = 0; flush_seen = 0; pcsel_seen = 0; done_seen = 0;
    endtask

    initial begin
        logic [3:0]  ldv_mr;
        logic [29:0] rnd_ins;
        ldv_mr = 4'b0011;
        bus.instr = '0; bus.instr_valid = 0; bus.cmp_flag = 0; bus.mem_ready = 0;

        // Reset state.
        step(0, 0, '0, 0, 0);
        step(0, 1, I_SUMFV, 0, 0);

        // Pass-through scalar op.
        step(1, 1, I_SUMI, 0, 0);

        // SUMFV with mem_ready low throughout: not a memory op, runs flat out.
        clear_tally();
        step(1, 1, I_SUMFV, 0, 0);
        repeat (4) step(1, 0, I_NOP, 0, 0);
        chk("sumfv_stall_cycles", stall_seen, 4);
        chk("sumfv_done_pulses",  done_seen, 1);

        // LDV with two wait cycles at lane 1.
        clear_tally();
        step(1, 1, I_LDV, 0, 1);
        step(1, 0, I_NOP, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, I_NOP, 0, ldv_mr[3-i]);
        step(1, 0, I_NOP, 0, 1);
        chk("ldv_stall_cycles", stall_seen, 6);
        chk("ldv_done_pulses",  done_seen, 1);
        step(1, 0, I_NOP, 0, 1);

        // Taken JEQ: pc_sel one cycle, flush two.
        clear_tally();
        step(1, 1, I_JEQ, 1, 0);
        step(1, 1, I_NOP, 0, 0);
        step(1, 0, I_NOP, 0, 0);
        chk("jeq_pcsel_cycles", pcsel_seen, 1);
        chk("jeq_flush_cycles", flush_seen, 2);

        // Not-taken JEQ.
        step(1, 1, I_JEQ, 0, 0);

        // MULFV aborted by reset during lane 2.
        clear_tally();
        step(1, 1, I_MULFV, 0, 0);
        step(1, 0, I_NOP, 0, 0);
        step(1, 0, I_NOP, 0, 0);
        step(0, 0, I_NOP, 0, 0);
        step(1, 1, I_NOP, 0, 0);
        chk("mulfv_abort_done", done_seen, 0);

        // SETFV completes, J accepted immediately afterwards.
        clear_tally();
        step(1, 1, I_SETFV, 0, 0);
        repeat (4) step(1, 0, I_NOP, 0, 0);
        step(1, 1, I_J, 0, 0);
        step(1, 0, I_NOP, 0, 0);
        chk("setfv_j_pcsel", pcsel_seen, 1);
        chk("setfv_j_done",  done_seen, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            rnd_ins = 30'($urandom);
            step(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 1)),
                 rnd_ins, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
